cnn_out_collector: RTL and testbench
====================================

Name: cnn_out_collector

Overview:
- Downstream stage of the CNN core.
- Captures the CNN result burst: N_OUT consecutive IEEE-754 single-precision words qualified by CNN out_valid.
- Tracks a running arg-max (class index) while capturing, checks the burst length, and replays the buffered words to a consumer over a valid/ready interface.
- Decouples the CNN's fixed-timing output burst from a back-pressuring consumer (host bus or scoreboard).

Parameters:
- N_OUT, 4, words per CNN result burst.
- IDX_W, 2, width of word index and class index; must satisfy 2^IDX_W >= N_OUT.

Ports:
- clk  input  1  system clock; all registers on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  connected to CNN out_valid; high for each captured word.
- in_data  input  32  connected to CNN out; IEEE-754 single.
- res_valid  output  1  buffered word available.
- res_ready  input  1  consumer accepts the word when res_valid and res_ready are both high.
- res_data  output  32  buffered word at the current read index; words leave in capture order.
- res_last  output  1  high with the final word (index N_OUT-1).
- cls_idx  output  IDX_W  index of the largest captured word; valid and stable while res_valid is high.
- err_len  output  1  one-cycle pulse: burst length was not N_OUT; the burst is discarded.
- err_busy  output  1  one-cycle pulse: a burst started while in DRAIN; that burst is ignored.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; buffer, counters and max register cleared.
- Word ordering key for compare: if sign=1, key = ~bits; else key = bits ^ 32'h8000_0000. Compare keys unsigned.
  - Consequence: -0 < +0. NaN inputs are not handled unless CNN_COLLECT_NAN_CHK_EN is defined.
- IDLE:
  - in_valid=1: store word 0, max_key=key(word), cls=0, cnt=1, go to CAPT.
- CAPT:
  - in_valid=1 and cnt<N_OUT: store at index cnt; if key > max_key (strictly greater, so ties keep the lowest index), update max_key and cls=cnt; cnt++.
  - in_valid=1 and cnt>=N_OUT: word not stored; set overflow flag.
  - in_valid=0 with cnt==N_OUT and no overflow: go to DRAIN; res_valid=1 the next cycle.
    - Latency: last word at cycle t gives res_valid at t+2.
  - in_valid=0 with short burst or overflow: err_len pulses for 1 cycle; return to IDLE; buffer contents discarded.
- DRAIN:
  - res_valid=1; res_data=buf[rd]; res_last=(rd==N_OUT-1); cls_idx held.
  - Handshake (res_valid & res_ready): rd++.
  - Handshake with res_last: res_valid=0 next cycle; state IDLE; rd=0.
  - res_ready low: outputs held stable, with no limit on wait.
  - in_valid rising edge while in DRAIN: err_busy pulses 1 cycle; that whole burst is ignored. Subsequent in_valid-high cycles of the same burst produce no further pulse.
  - Burst continuing after DRAIN exits: the IDLE transition waits for in_valid=0 first. The tail of an ignored burst is never captured as a new burst.
- Handshake rules: res_valid never drops before acceptance; res_data/res_last/cls_idx constant while res_valid=1 and res_ready=0.
- Reset mid-operation: immediate return to IDLE with all outputs 0; partial burst lost.

Optional Feature:
- Macro: CNN_COLLECT_NAN_CHK_EN.
- Defined: adds output port nan_flag (1 bit), valid with res_valid. It is set if any captured word has exponent 8'hFF with nonzero mantissa. NaN words never win arg-max, and cls_idx=0 if all words are NaN. nan_flag is 0 at reset.
- Undefined: no nan_flag port; NaN words compare purely by ordering key.

Test Plan:
- Burst 3F800000, 40000000, BF800000, 3F000000 with res_ready=1 -> res_valid at t+2; words out in the same order over 4 cycles; res_last on the 4th; cls_idx=1.
- Burst 40400000, 40400000, 00000000, C0000000 with res_ready toggling 1,0,0,1,... -> tie resolves cls_idx=0; outputs stable during stalls; exactly 4 handshakes.
- 3-word burst, then 5-word burst -> err_len pulses one cycle after each burst ends; res_valid stays 0; next valid 4-word burst drains normally.
- Valid burst, res_ready=0, then second 4-word burst arrives -> err_busy one pulse at its first word; first burst drains intact; second burst never appears.
- Burst 80000000, 00000000, 80000000, 00000000 -> cls_idx=1 (+0 beats -0).
- rst_n low for one cycle mid-DRAIN -> res_valid=0 immediately; a following burst 3F800000 x4 gives cls_idx=0.
- With CNN_COLLECT_NAN_CHK_EN: burst 7FC00000, 3F800000, 40000000, 00000000 -> nan_flag=1, cls_idx=2.

Source files
------------

// File: rtl/cnn_out_collector.sv
// cnn_out_collector
//   Captures a fixed-length CNN result burst (N_OUT IEEE-754 single words),
//   tracks the arg-max class index while capturing, validates the burst
//   length and replays the buffered words over a valid/ready interface.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid, in_data  CNN output burst (out_valid / out)
//   res_valid/ready    replay handshake; res_data word, res_last final word
//   cls_idx            index of the largest captured word
//   err_len            1-cycle pulse: burst length was not N_OUT (discarded)
//   err_busy           1-cycle pulse: burst started while draining (ignored)
//   nan_flag           only with CNN_COLLECT_NAN_CHK_EN: a captured word was NaN
//
// Optional feature macro: CNN_COLLECT_NAN_CHK_EN
module cnn_out_collector #(
  parameter int N_OUT = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_last,
  output logic [IDX_W-1:0] cls_idx,
  output logic             err_len,
  output logic             err_busy
`ifdef CNN_COLLECT_NAN_CHK_EN
  ,
  output logic             nan_flag
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CAPT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(N_OUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  logic [1:0]       state;
  logic [31:0]      mem [N_OUT];
  logic [IDX_W:0]   cnt;
  logic [IDX_W-1:0] rd;
  logic [IDX_W-1:0] cls;
  logic [31:0]      max_key;
  logic             ovf;
  logic             in_valid_q;
  logic             skip;       // tail of a burst seen during DRAIN is still running
  logic [31:0]      in_key;
  logic             beats;

`ifdef CNN_COLLECT_NAN_CHK_EN
  logic in_nan;
  logic max_ok;                 // max_key holds a non-NaN word
  logic nan_seen;
  assign in_nan   = (&in_data[30:23]) & (|in_data[22:0]);
  assign nan_flag = nan_seen & res_valid;
`endif

  // Monotonic unsigned key for IEEE-754 ordering (-0 sorts below +0).
  function automatic logic [31:0] order_key(input logic [31:0] w);
    return w[31] ? ~w : (w ^ 32'h8000_0000);
  endfunction

  always_comb begin
    in_key = order_key(in_data);
`ifdef CNN_COLLECT_NAN_CHK_EN
    beats  = !in_nan && (!max_ok || (in_key > max_key));
`else
    beats  = in_key > max_key;
`endif
  end

  assign res_valid = (state == DRAIN);
  assign res_data  = res_valid ? mem[rd] : '0;
  assign res_last  = res_valid && (rd == LAST_IDX);
  assign cls_idx   = cls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem        <= '{default: '0};
      cnt        <= '0;
      rd         <= '0;
      cls        <= '0;
      max_key    <= '0;
      ovf        <= 1'b0;
      in_valid_q <= 1'b0;
      skip       <= 1'b0;
      err_len    <= 1'b0;
      err_busy   <= 1'b0;
`ifdef CNN_COLLECT_NAN_CHK_EN
      max_ok     <= 1'b0;
      nan_seen   <= 1'b0;
`endif
    end else begin
      in_valid_q <= in_valid;
      err_len    <= 1'b0;
      err_busy   <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_valid) begin
            skip <= 1'b0;
          end else if (!skip) begin
            mem[0]  <= in_data;
            max_key <= in_key;
            cls     <= '0;
            cnt     <= (IDX_W + 1)'(1);
            ovf     <= 1'b0;
            state   <= CAPT;
`ifdef CNN_COLLECT_NAN_CHK_EN
            max_ok   <= !in_nan;
            nan_seen <= in_nan;
`endif
          end
        end
        CAPT: begin
          if (in_valid) begin
            if (cnt < CNT_FULL) begin
              mem[cnt[IDX_W-1:0]] <= in_data;
              if (beats) begin
                max_key <= in_key;
                cls     <= cnt[IDX_W-1:0];
              end
`ifdef CNN_COLLECT_NAN_CHK_EN
              if (beats)  max_ok   <= 1'b1;
              if (in_nan) nan_seen <= 1'b1;
`endif
              cnt <= cnt + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
          end else if ((cnt == CNT_FULL) && !ovf) begin
            rd    <= '0;
            state <= DRAIN;
          end else begin
            err_len <= 1'b1;
            state   <= IDLE;
          end
        end
        DRAIN: begin
          // A burst seen here is flagged once and its remainder is skipped
          // even if it outlasts the drain.
          if (in_valid && !in_valid_q) err_busy <= 1'b1;
          skip <= in_valid;
          if (res_ready) begin
            if (rd == LAST_IDX) begin
              rd    <= '0;
              state <= IDLE;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_out_collector.sv
module tb_cnn_out_collector;

  localparam int N_OUT = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             res_last;
  logic [IDX_W-1:0] cls_idx;
  logic             err_len;
  logic             err_busy;
`ifdef CNN_COLLECT_NAN_CHK_EN
  logic             nan_flag;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_w [4];

  always #5 clk = ~clk;

  cnn_out_collector #(.N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_last (res_last),
    .cls_idx  (cls_idx),
    .err_len  (err_len),
    .err_busy (err_busy)
`ifdef CNN_COLLECT_NAN_CHK_EN
    ,
    .nan_flag (nan_flag)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a 4-word burst; returns just after the edge that captured the last word.
  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    exp_w[0] = a; exp_w[1] = b; exp_w[2] = c; exp_w[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = exp_w[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_n(input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Latency: res_valid low right after last word, high one edge later.
  task automatic expect_latency();
    chk("lat_early", {31'b0, res_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'b0, res_valid}, 32'd1);
  endtask

  // Drain with a cyclic ready pattern; checks every presented word.
  task automatic drain(input logic [IDX_W-1:0] exp_cls, input logic [7:0] pat);
    int hs;
    logic fire;
    hs = 0;
    for (int c = 0; c < 40 && hs < 4; c++) begin
      res_ready = pat[c % 8];
      chk("drain_valid", {31'b0, res_valid}, 32'd1);
      chk("drain_data", res_data, exp_w[hs]);
      chk("drain_last", {31'b0, res_last}, {31'b0, (hs == 3)});
      chk("drain_cls", {30'b0, cls_idx}, {30'b0, exp_cls});
      fire = res_ready & res_valid;
      tick();
      if (fire) hs++;
    end
    res_ready = 1'b0;
    chk("drain_hs", 32'(hs), 32'd4);
    chk("drain_done", {31'b0, res_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_last", {31'b0, res_last}, 32'd0);
    chk("rst_cls", {30'b0, cls_idx}, 32'd0);
    chk("rst_errlen", {31'b0, err_len}, 32'd0);
    chk("rst_errbusy", {31'b0, err_busy}, 32'd0);
`ifdef CNN_COLLECT_NAN_CHK_EN
    chk("rst_nan", {31'b0, nan_flag}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 1.0, 2.0, -1.0, 0.5 -> class 1, full-rate drain
    send4(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000);
    expect_latency();
    drain(2'd1, 8'hFF);

    // 3.0, 3.0, 0.0, -2.0 -> tie keeps index 0, ready 1,0,0,1,...
    send4(32'h4040_0000, 32'h4040_0000, 32'h0000_0000, 32'hC000_0000);
    expect_latency();
    drain(2'd0, 8'b1001_1001);

    // Short and long bursts are rejected
    send_n(3, 32'h3F80_0000);
    chk("short_errlen_pre", {31'b0, err_len}, 32'd0);
    tick();
    chk("short_errlen", {31'b0, err_len}, 32'd1);
    chk("short_valid", {31'b0, res_valid}, 32'd0);
    tick();
    chk("short_errlen_end", {31'b0, err_len}, 32'd0);
    send_n(5, 32'h4000_0000);
    tick();
    chk("long_errlen", {31'b0, err_len}, 32'd1);
    chk("long_valid", {31'b0, res_valid}, 32'd0);
    tick();
    chk("long_errlen_end", {31'b0, err_len}, 32'd0);
    chk("long_valid2", {31'b0, res_valid}, 32'd0);
    // 5.0, 4.0, -8.0, 8.0 -> class 3
    send4(32'h40A0_0000, 32'h4080_0000, 32'hC100_0000, 32'h4100_0000);
    expect_latency();
    drain(2'd3, 8'hFF);

    // Second burst during a stalled drain is flagged once and ignored
    send4(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000);
    expect_latency();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h4120_0000 + 32'(k);
      tick();
      chk("busy_pulse", {31'b0, err_busy}, {31'b0, (k == 0)});
      chk("busy_hold_data", res_data, 32'h3F80_0000);
    end
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    chk("busy_end", {31'b0, err_busy}, 32'd0);
    drain(2'd1, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_no_ghost", {31'b0, res_valid}, 32'd0);
    end

    // -0, +0, -0, +0 -> +0 wins, first +0 is index 1
    send4(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    expect_latency();
    drain(2'd1, 8'hFF);

    // Reset mid-drain
    send4(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000);
    expect_latency();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("mid_data", res_data, 32'h4000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, res_valid}, 32'd0);
    chk("mrst_data", res_data, 32'd0);
    chk("mrst_last", {31'b0, res_last}, 32'd0);
    chk("mrst_cls", {30'b0, cls_idx}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    expect_latency();
    drain(2'd0, 8'hFF);

`ifdef CNN_COLLECT_NAN_CHK_EN
    // NaN never wins; 2.0 at index 2 is the max
    send4(32'h7FC0_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000);
    expect_latency();
    chk("nan_flag", {31'b0, nan_flag}, 32'd1);
    drain(2'd2, 8'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
